// File: rtl/ro_pair_puf_eval_pkg.sv
// Shared types and constants for the RO-pair PUF evaluator.
// Build option: RO_PUF_SCRAMBLE_EN remaps challenge indices through SCRAMBLE_KEY.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_CMP    = 2'd3
  } state_e;

  localparam int          SETTLE_CYC   = 3;
  localparam logic [31:0] SCRAMBLE_KEY = 32'hA;

`ifdef RO_PUF_SCRAMBLE_EN
  localparam bit SCRAMBLE_ON = 1'b1;
`else
  localparam bit SCRAMBLE_ON = 1'b0;
`endif

  // Challenge index -> physical RO index; identity when scrambling is off.
  function automatic logic [31:0] map_ro(input logic [31:0] chal);
    return chal ^ (SCRAMBLE_KEY & {32{SCRAMBLE_ON}});
  endfunction

endpackage

// File: rtl/ro_pair_puf_eval_if.sv
// Request/result bundle between the PUF evaluator and its controller.
// Handshake: start_i is taken only on a clock edge where busy_o is low; done_o is a
// one-cycle pulse after which resp_o/tie_o/err_o/cnt_*_o hold until the next done_o.
interface ro_pair_puf_eval_if #(
  parameter int N_RO  = 16,
  parameter int SEL_W = $clog2(N_RO),
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             start_i;
  logic [SEL_W-1:0] chal_a_i;
  logic [SEL_W-1:0] chal_b_i;
  logic [WIN_W-1:0] win_len_i;
  logic             busy_o;
  logic             done_o;
  logic             resp_o;
  logic             tie_o;
  logic             err_o;
  logic [CNT_W-1:0] cnt_a_o;
  logic [CNT_W-1:0] cnt_b_o;

  modport master (
    output start_i, chal_a_i, chal_b_i, win_len_i,
    input  busy_o, done_o, resp_o, tie_o, err_o, cnt_a_o, cnt_b_o
  );

  modport slave (
    input  start_i, chal_a_i, chal_b_i, win_len_i,
    output busy_o, done_o, resp_o, tie_o, err_o, cnt_a_o, cnt_b_o
  );
endinterface

// File: rtl/ro_pair_puf_eval_edge_counter.sv
// Synchronises one asynchronous RO output and counts its rising edges
// into a saturating counter; clr empties the counter, en gates counting.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic sync1_q, sync2_q, prev_q;
  logic rise;

  // The synchroniser keeps running during clr so it is flushed with the new source.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && rise && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ro_pair_puf_eval.sv
// Ring-oscillator pair PUF evaluator: counts two selected ROs over a window and compares.
// Build option: RO_PUF_SCRAMBLE_EN (challenge scrambling, see ro_puf_pkg::map_ro).
module ro_pair_puf_eval
  import ro_puf_pkg::*;
#(
  parameter int N_RO  = 16,
  parameter int SEL_W = $clog2(N_RO),
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_RO-1:0]   ro_i,
  ro_pair_puf_eval_if.slave bus,
  output state_e            dbg_state_o
);
  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_a_q, sel_b_q;
  logic [WIN_W-1:0] win_q;
  logic [1:0]       settle_q;
  logic             err_q;
  logic [31:0]      phys_a, phys_b;
  logic             start_ok, illegal;
  logic             busy, cnt_clr, cnt_en;
  logic             ro_a, ro_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             done_q, resp_q, tie_q, err_out_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  assign phys_a   = map_ro(32'(bus.chal_a_i));
  assign phys_b   = map_ro(32'(bus.chal_b_i));
  assign illegal  = (phys_a == phys_b) || (phys_a >= 32'(N_RO)) || (phys_b >= 32'(N_RO));
  assign start_ok = (state_q == ST_IDLE) && bus.start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = illegal ? ST_CMP : ST_SETTLE;
      ST_SETTLE: if (settle_q == 2'd0) state_d = ST_COUNT;
      ST_COUNT:  if (win_q == WIN_W'(1)) state_d = ST_CMP;
      ST_CMP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    cnt_clr = (state_q == ST_SETTLE);
    cnt_en  = (state_q == ST_COUNT);
  end

  // Run parameters are captured once at start; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      err_q    <= 1'b0;
      win_q    <= '0;
      settle_q <= '0;
    end else if (start_ok) begin
      sel_a_q  <= phys_a[SEL_W-1:0];
      sel_b_q  <= phys_b[SEL_W-1:0];
      err_q    <= illegal;
      win_q    <= (bus.win_len_i == '0) ? WIN_W'(1) : bus.win_len_i;
      settle_q <= 2'(SETTLE_CYC - 1);
    end else begin
      if ((state_q == ST_SETTLE) && (settle_q != 2'd0)) settle_q <= settle_q - 2'd1;
      if ((state_q == ST_COUNT) && (win_q != WIN_W'(1))) win_q <= win_q - WIN_W'(1);
    end
  end

  assign ro_a = ro_i[sel_a_q];
  assign ro_b = ro_i[sel_b_q];

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ro_i   (ro_a),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ro_i   (ro_b),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt_b)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q    <= 1'b0;
      resp_q    <= 1'b0;
      tie_q     <= 1'b0;
      err_out_q <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      done_q <= (state_q == ST_CMP);
      if (state_q == ST_CMP) begin
        err_out_q <= err_q;
        if (err_q) begin
          resp_q  <= 1'b0;
          tie_q   <= 1'b0;
          cnt_a_q <= '0;
          cnt_b_q <= '0;
        end else begin
          resp_q  <= (cnt_a > cnt_b);
          tie_q   <= (cnt_a == cnt_b);
          cnt_a_q <= cnt_a;
          cnt_b_q <= cnt_b;
        end
      end
    end
  end

  assign bus.busy_o  = busy;
  assign bus.done_o  = done_q;
  assign bus.resp_o  = resp_q;
  assign bus.tie_o   = tie_q;
  assign bus.err_o   = err_out_q;
  assign bus.cnt_a_o = cnt_a_q;
  assign bus.cnt_b_o = cnt_b_q;
  assign dbg_state_o = state_q;
endmodule
